// File: rtl/psg_write_queue.sv
// Purpose: queue CPU sound-chip writes and issue them one at a time to two PSGs, honouring each chip's ready.
// Latency: write accepted at edge E0 appears as a one-cycle sn1_wr/sn2_wr pulse registered at edge E0+2.
// Backpressure: writes arriving while full (and no same-cycle pop) are dropped and flagged on sticky overflow.
module psg_write_queue #(
  parameter int DEPTH = 8,
  parameter int GAP   = 40
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       cpu_wr,
  input  logic       cpu_sel,
  input  logic [7:0] cpu_din,
  input  logic       sn1_rdy,
  input  logic       sn2_rdy,
  output logic       sn1_wr,
  output logic       sn2_wr,
  output logic [7:0] sn_dout,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [7:0]      GAP_LOAD = 8'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_WAIT_RDY
  } state_t;

  state_t          state;
  state_t          state_nxt;

  // Entry layout: bit 8 = target chip select, bits 7:0 = data byte.
  logic [8:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [8:0]      head;
  logic [8:0]      hold;
  logic [7:0]      gap_cnt;
  logic            head_rdy;
  logic            hold_rdy;
  logic            pop;
  logic            push;
  logic            drop;

  assign head     = mem[rd_ptr];
  assign head_rdy = head[8] ? sn2_rdy : sn1_rdy;
  assign hold_rdy = hold[8] ? sn2_rdy : sn1_rdy;

  // A full queue can still take a write when the FSM pops in the same cycle.
  assign push = cpu_wr && (!full || pop);
  assign drop = cpu_wr && full && !pop;
  assign busy = (state != ST_IDLE);

  // Occupancy arithmetic for the registered count and flags.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage array; no reset needed because count/pointers gate every read.
  always_ff @(posedge clk_sys) begin
    if (!reset && push) begin
      mem[wr_ptr] <= {cpu_sel, cpu_din};
    end
  end

  // Pointers, count, full/empty flags and sticky overflow.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
      if (drop) overflow <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; pop only happens from IDLE when the head's chip is ready.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && head_rdy) begin
          pop       = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_GAP;
      // Counter reaches zero on the edge that leaves GAP; ready is ignored here.
      ST_GAP: begin
        if (gap_cnt == 8'd1) state_nxt = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (hold_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Hold register, gap counter and registered chip-side outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold    <= '0;
      gap_cnt <= '0;
      sn1_wr  <= 1'b0;
      sn2_wr  <= 1'b0;
      sn_dout <= 8'h00;
    end else begin
      sn1_wr <= 1'b0;
      sn2_wr <= 1'b0;
      if (pop) hold <= head;
      case (state)
        ST_ISSUE: begin
          sn1_wr  <= !hold[8];
          sn2_wr  <= hold[8];
          sn_dout <= hold[7:0];
          gap_cnt <= GAP_LOAD;
        end
        ST_GAP:  gap_cnt <= gap_cnt - 1'b1;
        default: gap_cnt <= gap_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_psg_write_queue.sv
// Bench for psg_write_queue: table of single-write vectors plus hand-written corner sequences.
// Expected writes are queued when driven and compared when a pulse appears.
// All sampling is done on the falling edge, away from the active rising edge.
module tb_psg_write_queue;

  localparam int DEPTH = 8;
  localparam int GAP   = 40;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b0;
  logic       cpu_wr  = 1'b0;
  logic       cpu_sel = 1'b0;
  logic [7:0] cpu_din = 8'h00;
  logic       sn1_rdy = 1'b1;
  logic       sn2_rdy = 1'b1;
  logic       sn1_wr;
  logic       sn2_wr;
  logic [7:0] sn_dout;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       busy;

  psg_write_queue #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .cpu_wr   (cpu_wr),
    .cpu_sel  (cpu_sel),
    .cpu_din  (cpu_din),
    .sn1_rdy  (sn1_rdy),
    .sn2_rdy  (sn2_rdy),
    .sn1_wr   (sn1_wr),
    .sn2_wr   (sn2_wr),
    .sn_dout  (sn_dout),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic       sel;
    logic [7:0] din;
  } exp_t;

  typedef struct {
    logic       sel;
    logic [7:0] din;
    logic       exp_sn1;
    logic       exp_sn2;
    logic [7:0] exp_dout;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;
  int   last_pulse_cyc = -1;
  logic pulse_sn1, pulse_sn2, pulse_busy;
  logic [7:0] pulse_dout;
  exp_t exp_q[$];
  int   pulse_cyc_q[$];
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Pulse monitor and scoreboard.
  always @(negedge clk_sys) begin
    if (sn1_wr || sn2_wr) begin
      exp_t e;
      chk("exclusive_wr", {31'd0, sn1_wr & sn2_wr}, 32'd0);
      if (last_pulse_cyc >= 0)
        chk("min_spacing", {31'd0, (cyc - last_pulse_cyc) >= GAP + 2}, 32'd1);
      chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pulse", {23'd0, sn2_wr, sn_dout}, {23'd0, e.sel, e.din});
      end
      pulse_cnt++;
      last_pulse_cyc = cyc;
      pulse_cyc_q.push_back(cyc);
      pulse_sn1  = sn1_wr;
      pulse_sn2  = sn2_wr;
      pulse_dout = sn_dout;
      pulse_busy = busy;
    end
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic do_reset(input logic wr_during);
    reset   = 1'b1;
    cpu_wr  = wr_during;
    cpu_sel = 1'b0;
    cpu_din = 8'hEE;
    tick();
    reset  = 1'b0;
    cpu_wr = 1'b0;
    exp_q.delete();
    last_pulse_cyc = -1;
  endtask

  // Drive one write for one cycle; queue it as expected only if it should be accepted.
  task automatic cpu_write(input logic sel, input logic [7:0] din, input logic expect_accept);
    cpu_wr  = 1'b1;
    cpu_sel = sel;
    cpu_din = din;
    if (expect_accept) exp_q.push_back('{sel: sel, din: din});
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int budget, input string name);
    int n = 0;
    while (pulse_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, {31'd0, pulse_cnt >= target}, 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int acc;
    int base;
    int t;

    vecs[0] = '{sel: 1'b0, din: 8'h9F, exp_sn1: 1'b1, exp_sn2: 1'b0, exp_dout: 8'h9F};
    vecs[1] = '{sel: 1'b1, din: 8'h3C, exp_sn1: 1'b0, exp_sn2: 1'b1, exp_dout: 8'h3C};
    vecs[2] = '{sel: 1'b0, din: 8'h00, exp_sn1: 1'b1, exp_sn2: 1'b0, exp_dout: 8'h00};
    vecs[3] = '{sel: 1'b1, din: 8'hFF, exp_sn1: 1'b0, exp_sn2: 1'b1, exp_dout: 8'hFF};
    vecs[4] = '{sel: 1'b0, din: 8'hA5, exp_sn1: 1'b1, exp_sn2: 1'b0, exp_dout: 8'hA5};

    tick();
    do_reset(1'b1);
    chk("reset_flags", {25'd0, full, empty, overflow, busy, sn1_wr, sn2_wr}, {25'd0, 6'b010000});
    chk("reset_dout", {24'd0, sn_dout}, 32'd0);

    // Single writes: latency, target select, data, busy behaviour.
    for (int i = 0; i < 5; i++) begin
      acc = cyc + 1;
      cpu_write(vecs[i].sel, vecs[i].din, 1'b1);
      wait_pulses(pulse_cnt + 1, 10, $sformatf("vec%0d_pulse_seen", i));
      chk($sformatf("vec%0d_latency", i), last_pulse_cyc - acc, 32'd2);
      chk($sformatf("vec%0d_sn1", i), {31'd0, pulse_sn1}, {31'd0, vecs[i].exp_sn1});
      chk($sformatf("vec%0d_sn2", i), {31'd0, pulse_sn2}, {31'd0, vecs[i].exp_sn2});
      chk($sformatf("vec%0d_dout", i), {24'd0, pulse_dout}, {24'd0, vecs[i].exp_dout});
      chk($sformatf("vec%0d_busy_at_pulse", i), {31'd0, pulse_busy}, 32'd1);
      wait_idle(GAP + 10, $sformatf("vec%0d_busy_drops", i));
      tick();
    end

    // Burst of eight alternating writes with both chips ready.
    pulse_cyc_q.delete();
    base = pulse_cnt;
    for (int i = 0; i < 8; i++) cpu_write(i[0], 8'h80 + 8'(i), 1'b1);
    chk("burst_not_full", {31'd0, full}, 32'd0);
    wait_pulses(base + 8, 8 * (GAP + 2) + 20, "burst_all_pulses");
    for (int i = 1; i < 8 && i < pulse_cyc_q.size(); i++)
      chk($sformatf("burst_spacing%0d", i), pulse_cyc_q[i] - pulse_cyc_q[i-1], GAP + 2);
    wait_idle(GAP + 10, "burst_idle");

    // Fill with PSG1 stalled, drop one extra write, then drain.
    do_reset(1'b0);
    sn1_rdy = 1'b0;
    base = pulse_cnt;
    for (int i = 0; i < 8; i++) cpu_write(1'b0, 8'h10 + 8'(i), 1'b1);
    chk("fill_full", {30'd0, full, overflow}, {30'd0, 2'b10});
    chk("fill_no_pulse", pulse_cnt, base);
    cpu_write(1'b0, 8'hEE, 1'b0);
    chk("drop_overflow", {30'd0, full, overflow}, {30'd0, 2'b11});
    sn1_rdy = 1'b1;
    wait_pulses(base + 8, 8 * (GAP + 2) + 20, "drain_eight");
    repeat (GAP + 10) tick();
    chk("drain_exact_count", pulse_cnt, base + 8);
    chk("drain_empty_sticky", {29'd0, empty, busy, overflow}, {29'd0, 3'b101});

    // Full queue with a pop and a write in the same cycle.
    do_reset(1'b0);
    chk("reset_clears_overflow", {31'd0, overflow}, 32'd0);
    sn1_rdy = 1'b0;
    base = pulse_cnt;
    for (int i = 0; i < 8; i++) cpu_write(1'b0, 8'h20 + 8'(i), 1'b1);
    sn1_rdy = 1'b1;
    cpu_write(1'b1, 8'hD0, 1'b1);
    chk("pop_push_full", {30'd0, full, overflow}, {30'd0, 2'b10});
    wait_pulses(base + 9, 9 * (GAP + 2) + 20, "pop_push_drain");
    wait_idle(GAP + 10, "pop_push_idle");
    chk("pop_push_empty", {31'd0, empty}, 32'd1);

    // PSG2 not ready long after the gap expires.
    do_reset(1'b0);
    base = pulse_cnt;
    cpu_write(1'b1, 8'h55, 1'b1);
    cpu_write(1'b0, 8'h66, 1'b1);
    wait_pulses(base + 1, 10, "stall_first_pulse");
    sn2_rdy = 1'b0;
    repeat (GAP + 100) tick();
    chk("stall_no_pulse", pulse_cnt, base + 1);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    t = cyc;
    sn2_rdy = 1'b1;
    tick();
    chk("stall_idle_next", {31'd0, busy}, 32'd0);
    wait_pulses(base + 2, 10, "stall_second_pulse");
    chk("stall_release_latency", last_pulse_cyc - t, 32'd3);
    wait_idle(GAP + 10, "stall_idle");

    // Reset during GAP with three entries still queued.
    do_reset(1'b0);
    base = pulse_cnt;
    for (int i = 0; i < 4; i++) cpu_write(1'b0, 8'h40 + 8'(i), 1'b1);
    wait_pulses(base + 1, 10, "mid_reset_first_pulse");
    repeat (5) tick();
    chk("mid_reset_in_gap", {31'd0, busy}, 32'd1);
    do_reset(1'b1);
    chk("mid_reset_flags", {28'd0, empty, busy, full, overflow}, {28'd0, 4'b1000});
    repeat (3 * (GAP + 2) + 10) tick();
    chk("mid_reset_no_pulses", pulse_cnt, base + 1);
    chk("mid_reset_still_empty", {31'd0, empty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
